// File: rtl/sdio_pkg.sv
// Shared definitions for the 3-wire serial register link (master side):
// FSM state encoding, frame header codes and response framing constants.
package sdio_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_TRIG = 3'd2,
        ST_HUNT = 3'd3,
        ST_DATA = 3'd4,
        ST_GAPW = 3'd5
    } sdio_state_e;

    localparam logic [1:0] HDR_RD    = 2'b10;
    localparam logic [1:0] HDR_WR    = 2'b11;
    localparam int         RSP_W     = 32;
    localparam logic       START_BIT = 1'b1;

endpackage

// File: rtl/sdio_sck_gen.sv
// Serial clock divider: one sck period is 2*CLK_DIV clks, rising at phase 0
// and falling at phase CLK_DIV. Disabled means counter parked at 0, sck low.
module sdio_sck_gen #(
    parameter int CLK_DIV = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    output logic rise_tick_o,
    output logic fall_tick_o,
    output logic sck_o
);

    localparam int            CW   = $clog2(2 * CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(2 * CLK_DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(CLK_DIV);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sck_q, sck_d;

    assign rise_tick_o = en_i && (cnt_q == '0);
    assign fall_tick_o = en_i && (cnt_q == HALF);
    assign sck_o       = sck_q;

    always_comb begin
        cnt_d = '0;
        sck_d = 1'b0;
        if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
            sck_d = sck_q;
            if (rise_tick_o) begin
                sck_d = 1'b1;
            end else if (fall_tick_o) begin
                sck_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            sck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sck_q <= sck_d;
        end
    end

endmodule

// File: rtl/sdio_master.sv
// Initiator of the 3-wire serial register link: serialises read/write commands
// and collects the start-bit-prefixed response. Optional macro SDIO_MASTER_STATS_EN
// adds saturating transaction/timeout counters.
module sdio_master
    import sdio_pkg::*;
#(
    parameter int AW       = 8,
    parameter int CLK_DIV  = 8,
    parameter int HUNT_MAX = 8,
    parameter int GAP      = 2
) (
    input  logic          clk,
    input  logic          rst,
    // Command handshake: a command transfers on a clk where cmd_valid && cmd_ready;
    // cmd_ready is high only in IDLE, so the fields are latched exactly once.
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [AW-1:0] cmd_addr,
    input  logic [31:0]   cmd_wdata,
    output logic          rsp_valid,
    output logic [31:0]   rsp_rdata,
    output logic          rsp_err,
    output logic          busy,
    output logic          sdio_sck,
    output logic          sdio_mosi,
    input  logic          sdio_miso
`ifdef SDIO_MASTER_STATS_EN
    ,
    output logic [15:0]   stat_xfer_cnt,
    output logic [15:0]   stat_err_cnt
`endif
);

    localparam int FW  = AW + 2 + RSP_W;
    localparam int BCW = $clog2(FW + 1);
    localparam int HCW = $clog2(HUNT_MAX + 1);
    localparam int GCW = $clog2(GAP * CLK_DIV + 1);

    sdio_state_e       state_q, state_d;
    logic [FW-1:0]     sh_q, sh_d;
    logic [BCW-1:0]    len_q, len_d;
    logic [BCW-1:0]    bit_q, bit_d;
    logic [HCW-1:0]    hunt_q, hunt_d;
    logic [GCW-1:0]    gap_q, gap_d;
    logic [RSP_W-1:0]  rx_q, rx_d;
    logic              wr_q, wr_d;
    logic              mosi_q, mosi_d;
    logic              miso_q;
    logic              rsp_valid_q, rsp_valid_d;
    logic [RSP_W-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    logic              sck_en;
    logic              rise_tick;
    logic              fall_tick;

    assign sck_en = (state_q == ST_CMD) || (state_q == ST_TRIG) ||
                    (state_q == ST_HUNT) || (state_q == ST_DATA);

    sdio_sck_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sck_gen (
        .clk         (clk),
        .rst         (rst),
        .en_i        (sck_en),
        .rise_tick_o (rise_tick),
        .fall_tick_o (fall_tick),
        .sck_o       (sdio_sck)
    );

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign sdio_mosi = mosi_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    always_comb begin
        state_d     = state_q;
        sh_d        = sh_q;
        len_d       = len_q;
        bit_d       = bit_q;
        hunt_d      = hunt_q;
        gap_d       = gap_q;
        rx_d        = rx_q;
        wr_d        = wr_q;
        mosi_d      = mosi_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    wr_d    = cmd_write;
                    sh_d    = {(cmd_write ? HDR_WR : HDR_RD), cmd_addr,
                               (cmd_write ? cmd_wdata : 32'h0)};
                    len_d   = cmd_write ? BCW'(FW) : BCW'(AW + 2);
                    bit_d   = '0;
                    hunt_d  = '0;
                    state_d = ST_CMD;
                end
            end

            ST_CMD: begin
                if (rise_tick) begin
                    mosi_d = sh_q[FW-1];
                    sh_d   = {sh_q[FW-2:0], 1'b0};
                end
                if (fall_tick) begin
                    if (bit_q == len_q - BCW'(1)) begin
                        bit_d   = '0;
                        state_d = ST_TRIG;
                    end else begin
                        bit_d = bit_q + BCW'(1);
                    end
                end
            end

            // mosi drops to 0 here and is not touched again until the next command
            ST_TRIG: begin
                if (rise_tick) begin
                    mosi_d = 1'b0;
                end
                if (fall_tick) begin
                    state_d = ST_HUNT;
                end
            end

            ST_HUNT: begin
                if (fall_tick) begin
                    if (miso_q == START_BIT) begin
                        if (wr_q) begin
                            state_d     = ST_GAPW;
                            gap_d       = '0;
                            rsp_valid_d = 1'b1;
                            rsp_rdata_d = '0;
                            rsp_err_d   = 1'b0;
                        end else begin
                            bit_d   = '0;
                            state_d = ST_DATA;
                        end
                    end else if (hunt_q == HCW'(HUNT_MAX - 1)) begin
                        state_d     = ST_GAPW;
                        gap_d       = '0;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = '0;
                        rsp_err_d   = 1'b1;
                    end else begin
                        hunt_d = hunt_q + HCW'(1);
                    end
                end
            end

            ST_DATA: begin
                if (fall_tick) begin
                    rx_d = {rx_q[RSP_W-2:0], miso_q};
                    if (bit_q == BCW'(RSP_W - 1)) begin
                        state_d     = ST_GAPW;
                        gap_d       = '0;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = {rx_q[RSP_W-2:0], miso_q};
                        rsp_err_d   = 1'b0;
                    end else begin
                        bit_d = bit_q + BCW'(1);
                    end
                end
            end

            ST_GAPW: begin
                if (gap_q == GCW'(GAP * CLK_DIV - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + GCW'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            sh_q        <= '0;
            len_q       <= '0;
            bit_q       <= '0;
            hunt_q      <= '0;
            gap_q       <= '0;
            rx_q        <= '0;
            wr_q        <= 1'b0;
            mosi_q      <= 1'b0;
            miso_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            len_q       <= len_d;
            bit_q       <= bit_d;
            hunt_q      <= hunt_d;
            gap_q       <= gap_d;
            rx_q        <= rx_d;
            wr_q        <= wr_d;
            mosi_q      <= mosi_d;
            miso_q      <= sdio_miso;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

`ifdef SDIO_MASTER_STATS_EN
    logic [15:0] xfer_cnt_q;
    logic [15:0] err_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            xfer_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else if (rsp_valid_q) begin
            if (xfer_cnt_q != 16'hFFFF) begin
                xfer_cnt_q <= xfer_cnt_q + 16'd1;
            end
            if (rsp_err_q && (err_cnt_q != 16'hFFFF)) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    assign stat_xfer_cnt = xfer_cnt_q;
    assign stat_err_cnt  = err_cnt_q;
`endif

endmodule

// File: tb/tb_sdio_master.sv
// Directed bench for sdio_master with a behavioural slave on sck/mosi/miso.
// Build with SDIO_MASTER_STATS_EN defined to include the statistics checks.
module tb_sdio_master;

    localparam int AW       = 8;
    localparam int CLK_DIV  = 8;
    localparam int HUNT_MAX = 8;
    localparam int GAP      = 2;
    localparam int NOM_PER  = AW + 36;
    localparam int GAP_CLKS = GAP * CLK_DIV;

    logic          clk;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [31:0]   cmd_wdata;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          busy;
    logic          sdio_sck;
    logic          sdio_mosi;
    logic          sdio_miso;
`ifdef SDIO_MASTER_STATS_EN
    logic [15:0]   stat_xfer_cnt;
    logic [15:0]   stat_err_cnt;
`endif

    sdio_master #(
        .AW       (AW),
        .CLK_DIV  (CLK_DIV),
        .HUNT_MAX (HUNT_MAX),
        .GAP      (GAP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .sdio_sck  (sdio_sck),
        .sdio_mosi (sdio_mosi),
        .sdio_miso (sdio_miso)
`ifdef SDIO_MASTER_STATS_EN
        ,
        .stat_xfer_cnt (stat_xfer_cnt),
        .stat_err_cnt  (stat_err_cnt)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard counters ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- slave model and bus monitor ----------------
    logic        slave_en;
    logic [31:0] slave_rdata;

    int          rise_cnt, fall_cnt, frame_len;
    int          rsp_cnt = 0;
    int          last_rises, gap_len, gap_rises, last_gap, last_gap_rises;
    logic        is_wr, tail_bad, in_gap, sck_prev, busy_prev;
    logic [63:0] cap;
    logic [31:0] last_rdata;
    logic        last_err;

    always @(negedge clk) begin
        if (!rst) begin
            rise_cnt  = 0;
            fall_cnt  = 0;
            frame_len = 0;
            is_wr     = 1'b0;
            tail_bad  = 1'b0;
            in_gap    = 1'b0;
            sck_prev  = 1'b0;
            busy_prev = 1'b0;
            cap       = '0;
            sdio_miso = 1'b0;
        end else begin
            if (busy && !busy_prev) begin
                rise_cnt  = 0;
                fall_cnt  = 0;
                frame_len = 0;
                is_wr     = 1'b0;
                tail_bad  = 1'b0;
                cap       = '0;
                sdio_miso = 1'b0;
            end
            if (sdio_sck && !sck_prev) begin
                rise_cnt++;
                if (in_gap) gap_rises++;
                sdio_miso = 1'b0;
                if (slave_en && frame_len != 0) begin
                    if (rise_cnt == frame_len + 2) begin
                        sdio_miso = 1'b1;
                    end else if (!is_wr && rise_cnt >= frame_len + 3 && rise_cnt <= frame_len + 34) begin
                        sdio_miso = slave_rdata[31 - (rise_cnt - frame_len - 3)];
                    end
                end
            end
            if (!sdio_sck && sck_prev) begin
                fall_cnt++;
                if (fall_cnt == 2) begin
                    is_wr     = sdio_mosi;
                    frame_len = sdio_mosi ? AW + 34 : AW + 2;
                end
                if (frame_len == 0 || fall_cnt <= frame_len) begin
                    cap = {cap[62:0], sdio_mosi};
                end else if (sdio_mosi) begin
                    tail_bad = 1'b1;
                end
            end
            if (rsp_valid) begin
                rsp_cnt++;
                last_rdata = rsp_rdata;
                last_err   = rsp_err;
                last_rises = rise_cnt;
                in_gap     = 1'b1;
                gap_len    = 0;
                gap_rises  = 0;
            end else if (in_gap) begin
                gap_len++;
                if (sdio_sck) gap_rises++;
                if (cmd_ready) begin
                    in_gap         = 1'b0;
                    last_gap       = gap_len;
                    last_gap_rises = gap_rises;
                end
            end
            sck_prev  = sdio_sck;
            busy_prev = busy;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_cmd(input logic wr, input logic [AW-1:0] addr, input logic [31:0] wdata);
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_valid = 1'b1;
    endtask

    // Wait until the presented command is taken; optionally keep cmd_valid high after.
    task automatic wait_accept(input bit hold);
        bit ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        @(negedge clk);
        #1;
        if (!hold) cmd_valid = 1'b0;
        check("accept", 64'(ok), 64'd1);
    endtask

    task automatic wait_rsp();
        int start = rsp_cnt;
        bit ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (rsp_cnt != start) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        check("rsp_wait", 64'(ok), 64'd1);
    endtask

    task automatic wait_ready();
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (cmd_ready && !in_gap) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        check("ready_wait", 64'(ok), 64'd1);
    endtask

    // ---------------- directed test sequence ----------------
    initial begin
        int snap;
        rst         = 1'b0;
        cmd_valid   = 1'b0;
        cmd_write   = 1'b0;
        cmd_addr    = '0;
        cmd_wdata   = '0;
        slave_en    = 1'b1;
        slave_rdata = 32'hDEADBEEF;
        sdio_miso   = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        check("rst_sck",       64'(sdio_sck),  64'd0);
        check("rst_mosi",      64'(sdio_mosi), 64'd0);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_busy",      64'(busy),      64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        check("rst_rsp_err",   64'(rsp_err),   64'd0);
        rst = 1'b1;
        @(negedge clk);
        #1;

        // read 0x5A, slave answers 0xDEADBEEF
        set_cmd(1'b0, 8'h5A, 32'h0);
        wait_accept(1'b0);
        wait_rsp();
        check("rd_frame",   cap, {54'b0, 2'b10, 8'h5A});
        check("rd_rdata",   64'(last_rdata), 64'hDEADBEEF);
        check("rd_err",     64'(last_err),   64'd0);
        check("rd_periods", 64'(last_rises), 64'(NOM_PER));
        check("rd_tail",    64'(tail_bad),   64'd0);
        wait_ready();
        check("rd_gap",     64'(last_gap),   64'(GAP_CLKS));

        // write 0x3C / 0x12345678
        set_cmd(1'b1, 8'h3C, 32'h12345678);
        wait_accept(1'b0);
        wait_rsp();
        check("wr_frame",   cap, {22'b0, 2'b11, 8'h3C, 32'h12345678});
        check("wr_rdata",   64'(last_rdata), 64'd0);
        check("wr_err",     64'(last_err),   64'd0);
        check("wr_periods", 64'(last_rises), 64'(NOM_PER));
        check("wr_tail",    64'(tail_bad),   64'd0);
        wait_ready();

        // timeout: slave silent, read 0x01
        slave_en = 1'b0;
        set_cmd(1'b0, 8'h01, 32'h0);
        wait_accept(1'b0);
        wait_rsp();
        check("to_frame",   cap, {54'b0, 2'b10, 8'h01});
        check("to_err",     64'(last_err),   64'd1);
        check("to_rdata",   64'(last_rdata), 64'd0);
        check("to_periods", 64'(last_rises), 64'(AW + 3 + HUNT_MAX));
        wait_ready();
        check("to_gap",     64'(last_gap),   64'(GAP_CLKS));
        slave_en = 1'b1;

        // back-to-back: cmd_valid held across write then read
        slave_rdata = 32'h13579BDF;
        set_cmd(1'b1, 8'h77, 32'hA5A5F00F);
        wait_accept(1'b1);
        set_cmd(1'b0, 8'h22, 32'hFFFFFFFF);
        wait_rsp();
        check("b2b_wr_frame", cap, {22'b0, 2'b11, 8'h77, 32'hA5A5F00F});
        check("b2b_wr_err",   64'(last_err),   64'd0);
        check("b2b_wr_rdata", 64'(last_rdata), 64'd0);
        wait_accept(1'b0);
        check("b2b_gap",       64'(last_gap),       64'(GAP_CLKS));
        check("b2b_gap_sck",   64'(last_gap_rises), 64'd0);
        wait_rsp();
        check("b2b_rd_frame",   cap, {54'b0, 2'b10, 8'h22});
        check("b2b_rd_rdata",   64'(last_rdata), 64'h13579BDF);
        check("b2b_rd_err",     64'(last_err),   64'd0);
        check("b2b_rd_periods", 64'(last_rises), 64'(NOM_PER));
        wait_ready();

`ifdef SDIO_MASTER_STATS_EN
        check("stat_xfer", 64'(stat_xfer_cnt), 64'd5);
        check("stat_err",  64'(stat_err_cnt),  64'd1);
`endif

        // reset during CMD bit 5
        set_cmd(1'b0, 8'h44, 32'h0);
        wait_accept(1'b0);
        begin
            bit ok = 1'b0;
            for (int i = 0; i < 2000; i++) begin
                if (rise_cnt == 5) begin
                    ok = 1'b1;
                    break;
                end
                @(negedge clk);
                #1;
            end
            check("mid_reach", 64'(ok), 64'd1);
        end
        snap = rsp_cnt;
        rst  = 1'b0;
        #1;
        check("mid_sck",       64'(sdio_sck),  64'd0);
        check("mid_mosi",      64'(sdio_mosi), 64'd0);
        check("mid_busy",      64'(busy),      64'd0);
        check("mid_cmd_ready", 64'(cmd_ready), 64'd1);
        repeat (4) @(negedge clk);
        #1;
        rst = 1'b1;
        repeat (40) @(negedge clk);
        #1;
        check("mid_no_rsp", 64'(rsp_cnt - snap), 64'd0);
`ifdef SDIO_MASTER_STATS_EN
        check("stat_xfer_rst", 64'(stat_xfer_cnt), 64'd0);
`endif

        // read after the aborted frame
        slave_rdata = 32'hCAFE1234;
        set_cmd(1'b0, 8'h81, 32'h0);
        wait_accept(1'b0);
        wait_rsp();
        check("post_frame",   cap, {54'b0, 2'b10, 8'h81});
        check("post_rdata",   64'(last_rdata), 64'hCAFE1234);
        check("post_err",     64'(last_err),   64'd0);
        check("post_periods", 64'(last_rises), 64'(NOM_PER));
        wait_ready();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
